// File: rtl/imem_loader_ctrl.sv
// rtl/imem_loader_ctrl.sv - UART byte-command loader for the instruction memory and CPU run sequencer
module imem_loader_ctrl #(
    parameter int          ADDR_W      = 12,
    parameter int          TIMEOUT_CYC = 1000000,
    parameter logic [7:0]  CMD_LOAD    = 8'h4C,
    parameter logic [7:0]  CMD_RUN     = 8'h52,
    parameter logic [7:0]  CMD_STOP    = 8'h53
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [15:0]       imem_wdata,
    output logic              pc_load,
    output logic [15:0]       pc_start,
    output logic              cpu_run,
    input  logic              cpu_halt,
    output logic              busy
);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] RESP_OK   = 8'h4B;
    localparam logic [7:0] RESP_DONE = 8'h44;
    localparam logic [7:0] RESP_ERR  = 8'h45;

    typedef enum logic [3:0] {
        S_IDLE, S_L_AH, S_L_AL, S_L_CNT, S_L_WH, S_L_WL,
        S_R_AH, S_R_AL, S_START, S_RUN, S_RESP
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       resp, resp_nxt;
    logic [15:0]      addr;
    logic [7:0]       count;
    logic [7:0]       word_hi;
    logic [TMO_W-1:0] tmo;
    logic             timed;
    logic             tmo_hit;
    logic             load_word;

    always_comb begin
        state_nxt = state;
        resp_nxt  = resp;
        load_word = 1'b0;
        timed     = state inside {S_L_AH, S_L_AL, S_L_CNT, S_L_WH, S_L_WL, S_R_AH, S_R_AL};
        tmo_hit   = timed && !rx_valid && (tmo == TMO_W'(TIMEOUT_CYC - 1));
        case (state)
            S_IDLE: if (rx_valid) begin
                if (rx_data == CMD_LOAD)      state_nxt = S_L_AH;
                else if (rx_data == CMD_RUN)  state_nxt = S_R_AH;
                else begin
                    state_nxt = S_RESP;
                    resp_nxt  = (rx_data == CMD_STOP) ? RESP_OK : RESP_ERR;
                end
            end
            S_L_AH:  if (rx_valid) state_nxt = S_L_AL;
            S_L_AL:  if (rx_valid) state_nxt = S_L_CNT;
            S_L_CNT: if (rx_valid) begin
                if (rx_data == 8'd0) begin
                    state_nxt = S_RESP;
                    resp_nxt  = RESP_OK;
                end else begin
                    state_nxt = S_L_WH;
                end
            end
            S_L_WH:  if (rx_valid) state_nxt = S_L_WL;
            S_L_WL:  if (rx_valid) begin
                load_word = 1'b1;
                if (count == 8'd1) begin
                    state_nxt = S_RESP;
                    resp_nxt  = RESP_OK;
                end else begin
                    state_nxt = S_L_WH;
                end
            end
            S_R_AH:  if (rx_valid) state_nxt = S_R_AL;
            S_R_AL:  if (rx_valid) state_nxt = S_START;
            S_START: state_nxt = S_RUN;
            // Halt outranks a simultaneous stop byte
            S_RUN: begin
                if (cpu_halt) begin
                    state_nxt = S_RESP;
                    resp_nxt  = RESP_DONE;
                end else if (rx_valid && rx_data == CMD_STOP) begin
                    state_nxt = S_RESP;
                    resp_nxt  = RESP_OK;
                end
            end
            S_RESP:  if (tx_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (tmo_hit) begin
            state_nxt = S_RESP;
            resp_nxt  = RESP_ERR;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            resp       <= 8'h00;
            addr       <= 16'h0000;
            count      <= 8'h00;
            word_hi    <= 8'h00;
            tmo        <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= 16'h0000;
            pc_start   <= 16'h0000;
        end else begin
            state   <= state_nxt;
            resp    <= resp_nxt;
            imem_we <= load_word;
            tmo     <= (!timed || rx_valid) ? '0 : tmo + 1'b1;
            if (rx_valid) begin
                case (state)
                    S_L_AH, S_R_AH: addr[15:8] <= rx_data;
                    S_L_AL:         addr[7:0]  <= rx_data;
                    S_R_AL: begin
                        addr[7:0] <= rx_data;
                        pc_start  <= {addr[15:8], rx_data};
                    end
                    S_L_CNT:        count      <= rx_data;
                    S_L_WH:         word_hi    <= rx_data;
                    default: ;
                endcase
            end
            // Only the memory-address bits advance, so the top of memory wraps to 0
            if (load_word) begin
                imem_waddr         <= addr[ADDR_W-1:0];
                imem_wdata         <= {word_hi, rx_data};
                addr[ADDR_W-1:0]   <= addr[ADDR_W-1:0] + 1'b1;
                count              <= count - 1'b1;
            end
        end
    end

    assign tx_valid = (state == S_RESP);
    assign tx_data  = tx_valid ? resp : 8'h00;
    assign pc_load  = (state == S_START);
    assign cpu_run  = (state == S_RUN);
    assign busy     = (state != S_IDLE);
endmodule

// File: tb/tb_imem_loader_ctrl.sv
// tb/tb_imem_loader_ctrl.sv - randomized self-checking bench for imem_loader_ctrl
module tb_imem_loader_ctrl;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_ready = 1'b1;
    logic        cpu_halt = 1'b0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        imem_we;
    logic [11:0] imem_waddr;
    logic [15:0] imem_wdata;
    logic        pc_load;
    logic [15:0] pc_start;
    logic        cpu_run;
    logic        busy;

    int n_total = 0;
    int n_bad = 0;

    typedef logic [27:0] wr_t;
    wr_t        got_wr[$];
    wr_t        exp_wr[$];
    logic [7:0] got_tx[$];
    logic [7:0] exp_tx[$];

    imem_loader_ctrl #(.ADDR_W(12), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .pc_load(pc_load), .pc_start(pc_start), .cpu_run(cpu_run),
        .cpu_halt(cpu_halt), .busy(busy)
    );

    always #5 clk = ~clk;

    always begin
        @(negedge clk);
        #2;
        if (reset_n && imem_we) got_wr.push_back({imem_waddr, imem_wdata});
        if (reset_n && tx_valid && tx_ready) got_tx.push_back(tx_data);
    end

    function automatic string fmt_wr(input wr_t q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf(" %03h:%04h", q[i][27:16], q[i][15:0])};
        return s;
    endfunction

    function automatic string fmt_tx(input logic [7:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf(" %02h", q[i])};
        return s;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic flush();
        got_wr.delete(); exp_wr.delete(); got_tx.delete(); exp_tx.delete();
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Reference: a load frame writes word i at (addr + i) mod 4096 and answers 'K'
    task automatic do_load(input logic [15:0] a, input logic [15:0] w[$]);
        send(8'h4C); gap();
        send(a[15:8]); gap();
        send(a[7:0]); gap();
        send(8'(w.size()));
        foreach (w[i]) begin
            gap(); send(w[i][15:8]);
            gap(); send(w[i][7:0]);
            exp_wr.push_back({12'((int'(a) + i) % 4096), w[i]});
        end
        exp_tx.push_back(8'h4B);
    endtask

    task automatic test_reset();
        bit ok;
        repeat (2) tick();
        n_total++;
        if ({tx_valid, tx_data, imem_we, imem_waddr, imem_wdata, pc_load, pc_start, cpu_run, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got tx_valid=%b tx_data=%h we=%b pc_load=%b cpu_run=%b busy=%b required all 0",
                     tx_valid, tx_data, imem_we, pc_load, cpu_run, busy);
        end
        reset_n = 1'b1;
        tick();
        wait_idle(ok);
        n_total++;
        if (!ok || tx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release got busy=%b tx_valid=%b required 0 0", busy, tx_valid);
        end
    endtask

    task automatic test_load();
        logic [15:0] w[$];
        bit ok;
        w = '{16'h0D00, 16'h0D41};
        do_load(16'd100, w);
        wait_idle(ok);
        n_total++;
        if (!ok || fmt_wr(got_wr) != fmt_wr(exp_wr) || fmt_tx(got_tx) != fmt_tx(exp_tx)) begin
            n_bad++;
            $display("FAIL load_directed got wr=[%s] tx=[%s] idle=%b required wr=[%s] tx=[%s] idle=1",
                     fmt_wr(got_wr), fmt_tx(got_tx), ok, fmt_wr(exp_wr), fmt_tx(exp_tx));
        end
        flush();
        for (int k = 0; k < 4; k++) begin
            w.delete();
            repeat ($urandom_range(1, 5)) w.push_back(16'($urandom));
            do_load(16'($urandom), w);
            wait_idle(ok);
            n_total++;
            if (!ok || fmt_wr(got_wr) != fmt_wr(exp_wr) || fmt_tx(got_tx) != fmt_tx(exp_tx)) begin
                n_bad++;
                $display("FAIL load_random%0d got wr=[%s] tx=[%s] idle=%b required wr=[%s] tx=[%s] idle=1",
                         k, fmt_wr(got_wr), fmt_tx(got_tx), ok, fmt_wr(exp_wr), fmt_tx(exp_tx));
            end
            flush();
        end
    endtask

    task automatic test_wrap();
        logic [15:0] w[$];
        bit ok;
        w = '{16'h1111, 16'h2222};
        do_load(16'h0FFF, w);
        wait_idle(ok);
        n_total++;
        if (!ok || fmt_wr(got_wr) != fmt_wr(exp_wr) || fmt_tx(got_tx) != fmt_tx(exp_tx)) begin
            n_bad++;
            $display("FAIL load_wrap got wr=[%s] tx=[%s] required wr=[%s] tx=[%s]",
                     fmt_wr(got_wr), fmt_tx(got_tx), fmt_wr(exp_wr), fmt_tx(exp_tx));
        end
        flush();
    endtask

    task automatic test_run_halt(input logic [15:0] a, input int dly);
        bit ok;
        send(8'h52); gap(); send(a[15:8]); gap(); send(a[7:0]);
        n_total++;
        if (pc_load !== 1'b1 || pc_start !== a || cpu_run !== 1'b0) begin
            n_bad++;
            $display("FAIL run_start got pc_load=%b pc_start=%0d cpu_run=%b required 1 %0d 0", pc_load, pc_start, cpu_run, a);
        end
        tick();
        n_total++;
        if (pc_load !== 1'b0 || cpu_run !== 1'b1) begin
            n_bad++;
            $display("FAIL run_entry got pc_load=%b cpu_run=%b required 0 1", pc_load, cpu_run);
        end
        repeat (dly - 1) tick();
        n_total++;
        if (cpu_run !== 1'b1 || tx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL run_hold got cpu_run=%b tx_valid=%b required 1 0", cpu_run, tx_valid);
        end
        cpu_halt = 1'b1;
        tx_ready = 1'b0;
        tick();
        cpu_halt = 1'b0;
        n_total++;
        if (cpu_run !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h44) begin
            n_bad++;
            $display("FAIL halt_resp got cpu_run=%b tx_valid=%b tx_data=%h required 0 1 44", cpu_run, tx_valid, tx_data);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h44) begin
                n_bad++;
                $display("FAIL tx_stall%0d got tx_valid=%b tx_data=%h required 1 44", i, tx_valid, tx_data);
            end
        end
        tx_ready = 1'b1;
        exp_tx.push_back(8'h44);
        wait_idle(ok);
        n_total++;
        if (!ok || fmt_tx(got_tx) != fmt_tx(exp_tx) || got_wr.size() != 0) begin
            n_bad++;
            $display("FAIL run_halt_tx got tx=[%s] writes=%0d idle=%b required tx=[%s] writes=0 idle=1",
                     fmt_tx(got_tx), got_wr.size(), ok, fmt_tx(exp_tx));
        end
        flush();
    endtask

    task automatic test_stop_drop(input logic [15:0] a);
        bit ok;
        send(8'h52); send(a[15:8]); send(a[7:0]);
        tick();
        send(8'h4C);
        tick();
        n_total++;
        if (cpu_run !== 1'b1 || tx_valid !== 1'b0 || imem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL run_drop got cpu_run=%b tx_valid=%b we=%b required 1 0 0", cpu_run, tx_valid, imem_we);
        end
        send(8'h53);
        n_total++;
        if (cpu_run !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h4B) begin
            n_bad++;
            $display("FAIL run_stop got cpu_run=%b tx_valid=%b tx_data=%h required 0 1 4b", cpu_run, tx_valid, tx_data);
        end
        exp_tx.push_back(8'h4B);
        wait_idle(ok);
        send(8'h52); send(a[15:8]); send(a[7:0]);
        tick();
        cpu_halt = 1'b1;
        send(8'h53);
        cpu_halt = 1'b0;
        exp_tx.push_back(8'h44);
        wait_idle(ok);
        n_total++;
        if (!ok || fmt_tx(got_tx) != fmt_tx(exp_tx) || got_wr.size() != 0) begin
            n_bad++;
            $display("FAIL stop_halt_tx got tx=[%s] writes=%0d required tx=[%s] writes=0",
                     fmt_tx(got_tx), got_wr.size(), fmt_tx(exp_tx));
        end
        flush();
    endtask

    task automatic test_errors();
        logic [7:0] b;
        logic [15:0] none[$];
        bit ok;
        int cyc;
        for (int k = 0; k < 4; k++) begin
            b = (k == 0) ? 8'h00 : 8'($urandom);
            if (b == 8'h4C || b == 8'h52) b = 8'h00;
            send(b);
            exp_tx.push_back(b == 8'h53 ? 8'h4B : 8'h45);
            wait_idle(ok);
        end
        send(8'h53);
        exp_tx.push_back(8'h4B);
        wait_idle(ok);
        n_total++;
        if (!ok || fmt_tx(got_tx) != fmt_tx(exp_tx)) begin
            n_bad++;
            $display("FAIL idle_bytes got tx=[%s] required tx=[%s]", fmt_tx(got_tx), fmt_tx(exp_tx));
        end
        flush();
        send(8'h4C); send(8'h00);
        cyc = 0;
        while (!tx_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        n_total++;
        if (cyc != TMO || tx_data !== 8'h45 || got_wr.size() != 0) begin
            n_bad++;
            $display("FAIL timeout got cycles=%0d tx_data=%h writes=%0d required %0d 45 0", cyc, tx_data, got_wr.size(), TMO);
        end
        wait_idle(ok);
        flush();
        do_load(16'h0010, none);
        wait_idle(ok);
        n_total++;
        if (!ok || fmt_tx(got_tx) != fmt_tx(exp_tx) || got_wr.size() != 0) begin
            n_bad++;
            $display("FAIL zero_count got tx=[%s] writes=%0d required tx=[%s] writes=0", fmt_tx(got_tx), got_wr.size(), fmt_tx(exp_tx));
        end
        flush();
    endtask

    task automatic test_reset_mid();
        logic [15:0] a, w0;
        logic [15:0] w[$];
        bit ok;
        a  = 16'($urandom);
        w0 = 16'($urandom);
        send(8'h4C); send(a[15:8]); send(a[7:0]); send(8'd3);
        send(w0[15:8]); send(w0[7:0]); send(8'($urandom));
        exp_wr.push_back({a[11:0], w0});
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if ({tx_valid, imem_we, pc_load, cpu_run, busy, pc_start} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_load got busy=%b we=%b cpu_run=%b required 0 0 0", busy, imem_we, cpu_run);
        end
        tick();
        reset_n = 1'b1;
        tick();
        n_total++;
        if (fmt_wr(got_wr) != fmt_wr(exp_wr) || got_tx.size() != 0) begin
            n_bad++;
            $display("FAIL reset_partial got wr=[%s] tx=%0d required wr=[%s] tx=0", fmt_wr(got_wr), got_tx.size(), fmt_wr(exp_wr));
        end
        flush();
        send(8'h52); send(a[15:8]); send(a[7:0]);
        tick();
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if ({tx_valid, tx_data, imem_we, pc_load, pc_start, cpu_run, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_run got cpu_run=%b busy=%b pc_start=%h required 0 0 0", cpu_run, busy, pc_start);
        end
        tick();
        reset_n = 1'b1;
        tick();
        repeat (3) w.push_back(16'($urandom));
        do_load(16'($urandom), w);
        wait_idle(ok);
        n_total++;
        if (!ok || fmt_wr(got_wr) != fmt_wr(exp_wr) || fmt_tx(got_tx) != fmt_tx(exp_tx)) begin
            n_bad++;
            $display("FAIL reload_after_reset got wr=[%s] tx=[%s] required wr=[%s] tx=[%s]",
                     fmt_wr(got_wr), fmt_tx(got_tx), fmt_wr(exp_wr), fmt_tx(exp_tx));
        end
        flush();
    endtask

    initial begin
        tick();
        test_reset();
        test_load();
        test_wrap();
        test_run_halt(16'd200, 20);
        test_run_halt(16'($urandom_range(1, 9) * 100), int'($urandom_range(2, 30)));
        test_stop_drop(16'($urandom));
        test_errors();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
